// File: rtl/param_seq_multiplier.sv
// param_seq_multiplier
//   Iterative shift-add multiplier for WIDTH-bit operands with a run/rdy
//   handshake. Each operation picks unsigned or two's-complement mode.
//   Signed mode uses radix-2 Booth recoding. Each operation takes WIDTH+2
//   cycles: accept, WIDTH iterations, then one DONE cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   run           start request, sampled only while rdy=1
//   signed_mode   0: unsigned x unsigned, 1: signed (Booth), sampled with run
//   multiplicand  operand A, sampled with run
//   multiplier    operand B, sampled with run
//   rdy           unit is idle and will accept run
//   busy          iterations in progress
//   done          one-cycle pulse, product valid from this cycle
//   iter          iterations completed in the current operation (0..WIDTH)
//   product       2*WIDTH-bit result, held until the next accepted run
module param_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 rdy,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     iter,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic               mode_reg;
  logic [WIDTH:0]     acc_u;
  logic [WIDTH-1:0]   acc_l;
  logic               q_m1;

  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     u_next;
  logic [WIDTH-1:0]   l_next;
  logic               last_iter;

  // One iteration step of the datapath.
  // The upper accumulator is one bit wider than the operand. In unsigned
  // mode, that extra bit holds the adder carry before the shift. In signed
  // mode, it keeps the sign correct when +2^(W-1) appears, as in the
  // -2^(W-1) * -2^(W-1) case.
  always_comb begin
    a_ext  = mode_reg ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    sum    = acc_u;
    u_next = acc_u;
    if (!mode_reg) begin
      // Unsigned: conditional add, then a logical shift that pulls the carry in.
      if (acc_l[0]) begin
        sum = {1'b0, acc_u[WIDTH-1:0]} + a_ext;
      end else begin
        sum = {1'b0, acc_u[WIDTH-1:0]};
      end
      u_next = {1'b0, sum[WIDTH:1]};
    end else begin
      // Booth: the bit pair (L[0], q_m1) selects add, subtract or no operation.
      // An arithmetic shift follows.
      case ({acc_l[0], q_m1})
        2'b01:   sum = acc_u + a_ext;
        2'b10:   sum = acc_u - a_ext;
        default: sum = acc_u;
      endcase
      u_next = {sum[WIDTH], sum[WIDTH:1]};
    end
    l_next    = {sum[0], acc_l[WIDTH-1:1]};
    last_iter = (iter == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath registers.
  // The product port is loaded only on the edge that enters DONE. Between
  // operations it therefore keeps the last result, and the partial
  // accumulator never shows on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rdy      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      iter     <= '0;
      product  <= '0;
      a_reg    <= '0;
      mode_reg <= 1'b0;
      acc_u    <= '0;
      acc_l    <= '0;
      q_m1     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (run) begin
            a_reg    <= multiplicand;
            mode_reg <= signed_mode;
            acc_u    <= '0;
            acc_l    <= multiplier;
            q_m1     <= 1'b0;
            iter     <= '0;
            rdy      <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_u <= u_next;
          acc_l <= l_next;
          q_m1  <= acc_l[0];
          iter  <= iter + CNT_W'(1);
          if (last_iter) begin
            product <= {u_next[WIDTH-1:0], l_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_multiplier.sv
// tb_param_seq_multiplier
//   Directed and random checks of param_seq_multiplier at WIDTH=8, plus a
//   short WIDTH=32 run on a second instance.
module tb_param_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        rdy;
  logic        busy;
  logic        done;
  logic [3:0]  iter;
  logic [15:0] product;

  logic        w_run;
  logic        w_signed_mode;
  logic [31:0] w_multiplicand;
  logic [31:0] w_multiplier;
  logic        w_rdy;
  logic        w_busy;
  logic        w_done;
  logic [5:0]  w_iter;
  logic [63:0] w_product;

  int vectors = 0;
  int miscompares = 0;

  // 10-unit clock period shared by both instances
  always #5 clk = ~clk;

  param_seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .run(run), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .rdy(rdy), .busy(busy), .done(done), .iter(iter), .product(product)
  );

  param_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .run(w_run), .signed_mode(w_signed_mode),
    .multiplicand(w_multiplicand), .multiplier(w_multiplier),
    .rdy(w_rdy), .busy(w_busy), .done(w_done), .iter(w_iter), .product(w_product)
  );

  // Waits (bounded) for rdy, then presents one run pulse. The task returns
  // #1 after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    for (int k = 0; k < 20 && !rdy; k++) begin
      @(posedge clk); #1;
    end
    multiplicand = a; multiplier = b; signed_mode = s; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // Counts edges until done is seen. cyc stays -1 if the bound expires.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    w_run = 1'b0; w_signed_mode = 1'b0; w_multiplicand = '0; w_multiplier = '0;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if ({rdy, busy, done} !== 3'b100) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 100", {rdy, busy, done}); end
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_product: got %h expected 0000", product); end
    vectors++; if (iter !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_iter: got %0d expected 0", iter); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({rdy, busy, done, product} !== {3'b100, 16'h0000}) begin miscompares++; $display("[TB] FAIL idle_no_run: got %b/%h expected 100/0000", {rdy, busy, done}, product); end
    vectors++; if ({w_rdy, w_busy, w_done, w_product} !== {3'b100, 64'h0}) begin miscompares++; $display("[TB] FAIL reset_w32: got %b/%h expected 100/0", {w_rdy, w_busy, w_done}, w_product); end
  endtask

  task automatic test_unsigned_max();
    int cyc;
    multiplicand = 8'hFF; multiplier = 8'hFF; signed_mode = 1'b0; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    vectors++; if ({rdy, busy} !== 2'b01) begin miscompares++; $display("[TB] FAIL u_accept_flags: got %b expected 01", {rdy, busy}); end
    wait_done(cyc);
    vectors++; if (cyc !== 8) begin miscompares++; $display("[TB] FAIL u_latency: got %0d expected 8", cyc); end
    vectors++; if (product !== 16'hFE01) begin miscompares++; $display("[TB] FAIL u_255x255: got %h expected FE01", product); end
    vectors++; if (iter !== 4'd8) begin miscompares++; $display("[TB] FAIL u_iter_at_done: got %0d expected 8", iter); end
    @(posedge clk); #1;
    vectors++; if ({rdy, busy, done, product} !== {3'b100, 16'hFE01}) begin miscompares++; $display("[TB] FAIL u_return_idle: got %b/%h expected 100/FE01", {rdy, busy, done}, product); end
  endtask

  task automatic test_signed_corner();
    int cyc;
    start_op(8'h80, 8'h80, 1'b1);
    wait_done(cyc);
    vectors++; if (product !== 16'h4000) begin miscompares++; $display("[TB] FAIL s_m128xm128: got %h expected 4000", product); end
  endtask

  task automatic test_signed_mixed();
    int cyc;
    start_op(8'hFD, 8'h05, 1'b1);
    wait_done(cyc);
    vectors++; if (product !== 16'hFFF1) begin miscompares++; $display("[TB] FAIL s_m3x5: got %h expected FFF1", product); end
    start_op(8'hFD, 8'h05, 1'b0);
    wait_done(cyc);
    vectors++; if (product !== 16'h04F1) begin miscompares++; $display("[TB] FAIL u_253x5: got %h expected 04F1", product); end
    start_op(8'h05, 8'hFD, 1'b1);
    wait_done(cyc);
    vectors++; if (product !== 16'hFFF1) begin miscompares++; $display("[TB] FAIL s_5xm3: got %h expected FFF1", product); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pa [4] = '{8'h00, 8'h5A, 8'h01, 8'hC8};
    logic [7:0]  pb [4] = '{8'h5A, 8'h00, 8'h01, 8'h03};
    logic [15:0] pe [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h0258};
    int cyc;
    for (int k = 0; k < 20 && !rdy; k++) begin @(posedge clk); #1; end
    multiplicand = pa[0]; multiplier = pb[0]; signed_mode = 1'b0; run = 1'b1;
    @(posedge clk); #1;
    multiplicand = pa[1]; multiplier = pb[1];
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc);
      vectors++; if (cyc !== 8) begin miscompares++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 8", i, cyc); end
      vectors++; if (product !== pe[i]) begin miscompares++; $display("[TB] FAIL b2b_product[%0d]: got %h expected %h", i, product, pe[i]); end
      if (i < 3) begin
        @(posedge clk); #1;
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rdy[%0d]: got %b expected 1", i, rdy); end
        @(posedge clk); #1;
        if (i + 2 < 4) begin multiplicand = pa[i+2]; multiplier = pb[i+2]; end
        if (i + 1 == 3) run = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    start_op(8'h64, 8'h64, 1'b0);
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    vectors++; if (iter !== 4'd3) begin miscompares++; $display("[TB] FAIL mid_iter: got %0d expected 3", iter); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if ({rdy, busy, done, iter, product} !== {3'b100, 4'd0, 16'h0000}) begin miscompares++; $display("[TB] FAIL mid_reset_state: got %b/%0d/%h expected 100/0/0000", {rdy, busy, done}, iter, product); end
    start_op(8'h07, 8'h09, 1'b0);
    wait_done(cyc);
    vectors++; if (product !== 16'h003F) begin miscompares++; $display("[TB] FAIL after_reset_7x9: got %h expected 003F", product); end
  endtask

  task automatic test_input_glitch();
    int cyc = -1;
    start_op(8'hB7, 8'h6D, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      run = 1'($urandom_range(0, 1));
      signed_mode = 1'($urandom_range(0, 1));
      multiplicand = 8'($urandom_range(0, 255));
      multiplier = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      if (done) begin cyc = k; break; end
    end
    run = 1'b0;
    vectors++; if (cyc !== 8) begin miscompares++; $display("[TB] FAIL glitch_latency: got %0d expected 8", cyc); end
    vectors++; if (product !== 16'hE0EB) begin miscompares++; $display("[TB] FAIL glitch_m73x109: got %h expected E0EB", product); end
    @(posedge clk); #1; @(posedge clk); #1;
    vectors++; if ({rdy, product} !== {1'b1, 16'hE0EB}) begin miscompares++; $display("[TB] FAIL glitch_hold: got %b/%h expected 1/E0EB", rdy, product); end
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic signed [15:0] sa, sb;
    logic [15:0] exp;
    int cyc;
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        sa = $signed(a);
        sb = $signed(b);
        exp = (m == 1) ? 16'(sa * sb) : 16'({8'h00, a} * {8'h00, b});
        start_op(a, b, 1'(m));
        wait_done(cyc);
        vectors++;
        if (cyc < 0 || product !== exp) begin
          miscompares++;
          $display("[TB] FAIL random_m%0d %h*%h: got %h (cyc %0d) expected %h", m, a, b, product, cyc, exp);
        end
      end
    end
  endtask

  task automatic test_wide32();
    logic [31:0] ops [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] exps [2] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 50 && !w_rdy; k++) begin @(posedge clk); #1; end
      w_multiplicand = ops[i]; w_multiplier = ops[i]; w_signed_mode = 1'(i); w_run = 1'b1;
      @(posedge clk); #1;
      w_run = 1'b0;
      cyc = -1;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk); #1;
        if (w_done) begin cyc = k; break; end
      end
      vectors++; if (cyc !== 32) begin miscompares++; $display("[TB] FAIL w32_latency[%0d]: got %0d expected 32", i, cyc); end
      vectors++; if (w_product !== exps[i]) begin miscompares++; $display("[TB] FAIL w32_product[%0d]: got %h expected %h", i, w_product, exps[i]); end
    end
  endtask

  // Runs the scenarios in order, then prints the summary line.
  initial begin
    $display("[TB] start");
    test_reset();
    test_unsigned_max();
    test_signed_corner();
    test_signed_mixed();
    test_back_to_back();
    test_mid_reset();
    test_input_glitch();
    test_random();
    test_wide32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
